instr_prefetch_queue: RTL
=========================

Name: instr_prefetch_queue

Overview:
Fetch-side front end of the 5-stage MIPS CPU.
- Generates sequential PCs and issues word reads to instruction memory.
- Buffers returned instructions, each tagged with its PC, in a small FIFO.
- Presents them to the decode stage with a valid/ready handshake.
- A redirect from branch/jump resolution (beq, bne, j, jal, jr) flushes all buffered and in-flight instructions and restarts fetch at the target.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
imem_req  output  1  read request to instruction memory this cycle.
imem_addr  output  32  byte address of the request; bits [1:0] are always 0.
imem_rdata  input  32  instruction word; valid exactly one cycle after imem_req.
redirect_valid  input  1  flush the queue and restart fetch.
redirect_pc  input  32  restart byte address; bits [1:0] are ignored and forced to 0.
instr_valid  output  1  queue head is valid for decode.
instr  output  32  queue head instruction.
instr_pc  output  32  byte address of the queue head.
decode_ready  input  1  decode accepts the head this cycle.
queue_level  output  $clog2(DEPTH)+1  entries currently held; excludes the in-flight request.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag and drop flag cleared.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, queue_level=0.
  - Reset has priority over redirect and all handshakes. A reset mid-stream discards everything, with no memory side effects.
- Memory timing: fixed 1-cycle read latency, at most one request in flight. Response for a request issued in cycle T is sampled at the edge ending T+1.
- Issue rule (combinational):
  - imem_req = rst_n & ~redirect_valid & (queue_level + inflight - pop < DEPTH).
  - pop = instr_valid & decode_ready.
  - imem_addr = fetch_pc; on each issued request, fetch_pc += 4, wrapping modulo 2^32.
- Capture: if the in-flight flag is set and the drop flag is clear, {imem_rdata, request PC} is pushed into the FIFO. Push and pop in the same cycle are legal at any level, including full. Overflow is impossible by construction; the bench asserts it never occurs.
- Output:
  - instr_valid = FIFO non-empty; instr and instr_pc are read from the head entry (registered storage).
  - Head holds stable while instr_valid=1 and decode_ready=0.
  - When instr_valid=0, instr and instr_pc hold their last values; decode must ignore them.
- Redirect (cycle R):
  - FIFO flushed at the edge ending R; queue_level=0 in R+1.
  - A response arriving in R is dropped.
  - No request is issued in R; fetch_pc=redirect_pc&~3 from R+1.
  - A pop in cycle R is still honoured, since decode consumed it before the flush.
  - Back-to-back redirects: the last one wins; each cycle restarts the sequence.
- Latency:
  - Request in R+1, capture at the end of R+2, instr_valid=1 in R+3 (3 cycles).
  - Same from reset release: first request in cycle 0, first instr_valid in cycle 2.
- Throughput: with decode_ready held at 1 and no redirects, one instruction per cycle sustained in steady state.
- PC wrap: 32'hFFFF_FFFC is followed by 32'h0000_0000; no error flag.
- No decode of instruction content; branch prediction is out of scope (always predict not-taken).

Decomposition:
- cpu_pkg holds: XLEN=32, INSTR_W=32, the PC_STEP=4 constant, RESET_PC default, and the fetch entry struct {instr, pc}.
- One sub-module: sync_fifo (parameterised width/depth; push, pop, flush, level, head outputs), reused later by the store buffer.
- The top level holds fetch_pc, the in-flight/drop flags and the issue logic.

Test Plan:
- Reset then run, decode_ready=1, imem[i]=32'h1000_0000+i: instr_valid first in cycle 2 with instr_pc=0, instr=32'h1000_0000; then pcs 4, 8, 12 on consecutive cycles.
- decode_ready=0 from cycle 0, DEPTH=4: imem_req deasserts once queue_level+inflight=4; queue_level=4, head stays pc=0. Set decode_ready=1: pcs 0, 4, 8, 12, 16 are delivered with no gap and no duplicates.
- redirect_valid with redirect_pc=32'h0000_008E while 3 entries are queued and one is in flight: queue_level=0 next cycle; the stale response is not delivered; the next instr_pc is 32'h0000_008C, 3 cycles after the redirect.
- Redirects in two consecutive cycles (to 0x40, then 0x80): only 0x80 and successors appear; no 0x40 entry is ever delivered.
- redirect_valid and pop in the same cycle: the popped instruction is counted as consumed exactly once; queue_level=0 afterwards.
- redirect_pc=32'hFFFF_FFF8, decode_ready=1: delivered pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert rst_n=0 mid-stream: all outputs take reset values at the next edge and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch front end and later pipeline blocks.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // Byte distance between sequential instruction words.
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Default fetch address after reset.
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One prefetched instruction tagged with the byte address it was read from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bus: instruction-memory port, redirect input and decode handshake.
// Latency: none (wiring only).
// Backpressure: decode_ready gates the queue head; the fetch unit throttles imem_req.
interface instr_prefetch_queue_if
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                imem_req;
  logic [XLEN-1:0]     imem_addr;
  logic [INSTR_W-1:0]  imem_rdata;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                instr_valid;
  logic [INSTR_W-1:0]  instr;
  logic [XLEN-1:0]     instr_pc;
  logic                decode_ready;
  logic [LVL_W-1:0]    queue_level;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, queue_level,
    input  imem_rdata, redirect_valid, redirect_pc, decode_ready
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, queue_level,
    output imem_rdata, redirect_valid, redirect_pc, decode_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush, occupancy level and a registered head output.
// Latency: a push into an empty FIFO is visible at the head one cycle later.
// Backpressure: caller must not push when full without a simultaneous pop; head holds while not popped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o,
  output logic [WIDTH-1:0]         head_dat_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_ok;

  // Next pointers, level and head; the head register keeps its last value once the FIFO drains.
  always_comb begin
    pop_ok   = pop_i & (count_q != '0);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    count_d  = count_q + LVL_W'(push_i) - LVL_W'(pop_ok);
    head_d   = head_q;
    if (count_d != '0) begin
      // If everything currently held is being popped, the new head is the word arriving now.
      head_d = (count_q == LVL_W'(pop_ok)) ? push_dat_i : mem_q[rd_ptr_d];
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = head_q;
    end
  end

  // Control state and head register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are only ever read behind a valid level, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign level_o    = count_q;
  assign empty_o    = (count_q == '0);
  assign head_dat_o = head_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: issues word reads, queues {instr, pc}, redirect flushes and restarts.
// Latency: 2 cycles from reset release, 3 cycles from a redirect, to the first valid instruction.
// Backpressure: decode_ready stalls the head; requests stop once queued plus in-flight reaches DEPTH.
module instr_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clock,
  input  logic                   rst_n,
  instr_prefetch_queue_if.master bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             issue;
  logic             pop;
  logic             push;
  fetch_entry_t     push_ent;
  fetch_entry_t     head_ent;
  logic [LVL_W-1:0] level;
  logic             empty;
  logic             unused_redirect_lsbs;

  // Redirect targets are word aligned; the low address bits are discarded.
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // Issue decision and fetch-address sequencing; a redirect suppresses issue and drops the arriving response.
  always_comb begin
    pop   = ~empty & bus.decode_ready;
    issue = rst_n & ~bus.redirect_valid &
            ((int'(level) + int'(inflight_q) - int'(pop)) < DEPTH);
    push           = inflight_q & ~bus.redirect_valid;
    push_ent.instr = bus.imem_rdata;
    push_ent.pc    = req_pc_q;

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  // Fetch address, address of the outstanding request and its in-flight flag.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_n_i    (rst_n),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .flush_i    (bus.redirect_valid),
    .level_o    (level),
    .empty_o    (empty),
    .head_dat_o (head_ent)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = ~empty;
  assign bus.instr       = head_ent.instr;
  assign bus.instr_pc    = head_ent.pc;
  assign bus.queue_level = level;

endmodule
